ddr2_idelay_rst_seq: RTL and testbench



---
 rtl/ddr2_idelay_pkg.sv | 21 ++
 rtl/ddr2_sync_ff.sv | 28 ++
 rtl/ddr2_idelay_rst_seq.sv | 153 +++++++++++++++
 tb/tb_ddr2_idelay_rst_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_idelay_pkg.sv
// Shared types and default timing for the DDR2 PHY IDELAYCTRL reset sequencer.
// All cycle counts are in the 200 MHz reference clock domain.
package ddr2_idelay_pkg;

  typedef enum logic [2:0] {
    RST_ASSERT = 3'd0,
    WAIT_RDY   = 3'd1,
    STABLE_CHK = 3'd2,
    READY      = 3'd3,
    ERROR      = 3'd4
  } seq_state_t;

  // 12 cycles at 5 ns gives 60 ns, safely above the 50 ns minimum pulse
  localparam int unsigned DEF_RST_PULSE_CYCLES   = 12;
  localparam int unsigned DEF_RDY_TIMEOUT_CYCLES = 2048;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ddr2_sync_ff.sv
// N-stage flag synchronizer, async active-low reset to 0.
// Reusable for any slow PHY status flag crossing into a local clock.
module ddr2_sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_reg[0] <= 1'b0;
    else        sync_reg[0] <= d;
  end

  for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_reg[gi] <= 1'b0;
      else        sync_reg[gi] <= sync_reg[gi-1];
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/ddr2_idelay_rst_seq.sv
// IDELAYCTRL reset/ready sequencer: pulses idelay_rst, qualifies ready as stable,
// then releases calibration reset; retries on timeout and latches a sticky error.
module ddr2_idelay_rst_seq
  import ddr2_idelay_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES   = DEF_RST_PULSE_CYCLES,
  parameter int unsigned STABLE_CYCLES      = 16,
  parameter int unsigned RDY_TIMEOUT_CYCLES = DEF_RDY_TIMEOUT_CYCLES,
  parameter int unsigned MAX_RETRIES        = 2,
  parameter int unsigned SYNC_STAGES        = 2
) (
  input  logic       clk200,
  input  logic       rst200_n,
  input  logic       idelay_ctrl_rdy,
  input  logic       restart,
  output logic       idelay_rst,
  output logic       calib_rst_n,
  output logic       seq_busy,
  output logic       seq_error,
  output logic       rdy_lost,
  output logic [1:0] retry_cnt
);

  localparam int unsigned PW = cnt_w(RST_PULSE_CYCLES);
  localparam int unsigned SW = cnt_w(STABLE_CYCLES);
  localparam int unsigned TW = cnt_w(RDY_TIMEOUT_CYCLES);
  localparam logic [PW-1:0] PULSE_LAST  = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(RDY_TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRIES);

  seq_state_t    state_reg, state_next;
  logic [PW-1:0] pulse_cnt_reg, pulse_cnt_next;
  logic [SW-1:0] stable_cnt_reg, stable_cnt_next;
  logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [1:0]    retry_cnt_reg, retry_cnt_next;
  logic          rdy_lost_next;
  logic          idelay_rst_reg, calib_rst_n_reg, seq_busy_reg, seq_error_reg, rdy_lost_reg;
  logic          rdy_s;
  logic          timeout;

  ddr2_sync_ff #(.STAGES(SYNC_STAGES)) u_rdy_sync (
    .clk   (clk200),
    .rst_n (rst200_n),
    .d     (idelay_ctrl_rdy),
    .q     (rdy_s)
  );

  assign timeout = (tmo_cnt_reg == TMO_LAST);

  // Restart overrides everything, then timeout, then ready-driven moves
  always_comb begin
    state_next      = state_reg;
    pulse_cnt_next  = pulse_cnt_reg;
    stable_cnt_next = stable_cnt_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    retry_cnt_next  = retry_cnt_reg;
    rdy_lost_next   = 1'b0;
    if (restart) begin
      state_next      = RST_ASSERT;
      pulse_cnt_next  = '0;
      stable_cnt_next = '0;
      tmo_cnt_next    = '0;
      retry_cnt_next  = '0;
    end else begin
      case (state_reg)
        RST_ASSERT: begin
          if (pulse_cnt_reg == PULSE_LAST) begin
            state_next     = WAIT_RDY;
            pulse_cnt_next = '0;
            tmo_cnt_next   = '0;
          end else begin
            pulse_cnt_next = pulse_cnt_reg + PW'(1);
          end
        end
        WAIT_RDY, STABLE_CHK: begin
          if (timeout) begin
            tmo_cnt_next    = '0;
            stable_cnt_next = '0;
            if (retry_cnt_reg < RETRY_MAX) begin
              retry_cnt_next = retry_cnt_reg + 2'd1;
              pulse_cnt_next = '0;
              state_next     = RST_ASSERT;
            end else begin
              state_next = ERROR;
            end
          end else begin
            // The timeout budget spans both states, so it keeps running across glitches
            tmo_cnt_next = tmo_cnt_reg + TW'(1);
            if (state_reg == WAIT_RDY) begin
              if (rdy_s) begin
                state_next      = STABLE_CHK;
                stable_cnt_next = '0;
              end
            end else if (!rdy_s) begin
              state_next = WAIT_RDY;
            end else if (stable_cnt_reg == STABLE_LAST) begin
              state_next      = READY;
              stable_cnt_next = '0;
            end else begin
              stable_cnt_next = stable_cnt_reg + SW'(1);
            end
          end
        end
        READY: begin
          if (!rdy_s) begin
            state_next     = RST_ASSERT;
            pulse_cnt_next = '0;
            retry_cnt_next = '0;
            rdy_lost_next  = 1'b1;
          end
        end
        ERROR: ;
        default: state_next = RST_ASSERT;
      endcase
    end
  end

  always_ff @(posedge clk200 or negedge rst200_n) begin
    if (!rst200_n) begin
      state_reg       <= RST_ASSERT;
      pulse_cnt_reg   <= '0;
      stable_cnt_reg  <= '0;
      tmo_cnt_reg     <= '0;
      retry_cnt_reg   <= '0;
      idelay_rst_reg  <= 1'b1;
      calib_rst_n_reg <= 1'b0;
      seq_busy_reg    <= 1'b1;
      seq_error_reg   <= 1'b0;
      rdy_lost_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pulse_cnt_reg   <= pulse_cnt_next;
      stable_cnt_reg  <= stable_cnt_next;
      tmo_cnt_reg     <= tmo_cnt_next;
      retry_cnt_reg   <= retry_cnt_next;
      idelay_rst_reg  <= (state_next == RST_ASSERT);
      calib_rst_n_reg <= (state_next == READY);
      seq_busy_reg    <= (state_next == RST_ASSERT) || (state_next == WAIT_RDY) ||
                         (state_next == STABLE_CHK);
      seq_error_reg   <= (state_next == ERROR);
      rdy_lost_reg    <= rdy_lost_next;
    end
  end

  assign idelay_rst  = idelay_rst_reg;
  assign calib_rst_n = calib_rst_n_reg;
  assign seq_busy    = seq_busy_reg;
  assign seq_error   = seq_error_reg;
  assign rdy_lost    = rdy_lost_reg;
  assign retry_cnt   = retry_cnt_reg;

endmodule

// File: tb/tb_ddr2_idelay_rst_seq.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized
// ready/restart traffic, all compared every cycle against a run-length based model.
module tb_ddr2_idelay_rst_seq;

  localparam int PULSE   = 12;
  localparam int STABLE  = 16;
  localparam int TMO     = 2048;
  localparam int RETRIES = 2;
  localparam int SYNC    = 2;

  localparam int M_PULSE = 0;
  localparam int M_SEEK  = 1;
  localparam int M_READY = 2;
  localparam int M_ERROR = 3;

  logic       clk200 = 1'b0;
  logic       rst200_n = 1'b0;
  logic       idelay_ctrl_rdy = 1'b0;
  logic       restart = 1'b0;
  logic       idelay_rst, calib_rst_n, seq_busy, seq_error, rdy_lost;
  logic [1:0] retry_cnt;

  int compared = 0;
  int mismatched = 0;
  int lost_total = 0;

  always #5 clk200 = ~clk200;

  ddr2_idelay_rst_seq dut (
    .clk200          (clk200),
    .rst200_n        (rst200_n),
    .idelay_ctrl_rdy (idelay_ctrl_rdy),
    .restart         (restart),
    .idelay_rst      (idelay_rst),
    .calib_rst_n     (calib_rst_n),
    .seq_busy        (seq_busy),
    .seq_error       (seq_error),
    .rdy_lost        (rdy_lost),
    .retry_cnt       (retry_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model: mode + time in mode + length of the current run of synchronized-ready samples
  int  m_mode = M_PULSE;
  int  m_age = 0;
  int  m_run = 0;
  int  m_retries = 0;
  bit  m_lost = 1'b0;
  bit  m_rs;
  bit  samp_q[$];

  always begin
    @(posedge clk200 or negedge rst200_n);
    if (!rst200_n) begin
      m_mode = M_PULSE; m_age = 0; m_run = 0; m_retries = 0; m_lost = 1'b0;
      samp_q.delete();
    end else begin
      m_rs = (samp_q.size() >= SYNC) ? samp_q[samp_q.size() - SYNC] : 1'b0;
      samp_q.push_back(idelay_ctrl_rdy);
      if (samp_q.size() > 8) void'(samp_q.pop_front());
      m_lost = 1'b0;
      if (restart) begin
        m_mode = M_PULSE; m_age = 0; m_run = 0; m_retries = 0;
      end else if (m_mode == M_PULSE) begin
        m_age++;
        if (m_age == PULSE) begin m_mode = M_SEEK; m_age = 0; m_run = 0; end
      end else if (m_mode == M_SEEK) begin
        m_age++;
        if (m_age == TMO) begin
          m_age = 0; m_run = 0;
          if (m_retries < RETRIES) begin m_retries++; m_mode = M_PULSE; end
          else m_mode = M_ERROR;
        end else begin
          m_run = m_rs ? m_run + 1 : 0;
          if (m_run == STABLE + 1) begin m_mode = M_READY; m_run = 0; end
        end
      end else if (m_mode == M_READY) begin
        if (!m_rs) begin m_mode = M_PULSE; m_age = 0; m_lost = 1'b1; m_retries = 0; end
      end
    end
  end

  logic [6:0] exp_v, act_v;
  always @(negedge clk200) begin
    exp_v = {m_mode == M_PULSE, m_mode == M_READY, (m_mode == M_PULSE) || (m_mode == M_SEEK),
             m_mode == M_ERROR, m_lost, 2'(m_retries)};
    act_v = {idelay_rst, calib_rst_n, seq_busy, seq_error, rdy_lost, retry_cnt};
    check("cycle_outputs{irst,calib,busy,err,lost,retry}", int'(act_v), int'(exp_v));
    if (rdy_lost) lost_total++;
  end

  initial begin
    int n;
    int base;
    int err_at;
    int run_left;
    bit prev;
    int starts[$];
    int rets[$];

    $display("scenario: power-up reset values");
    repeat (3) @(negedge clk200);
    check("rst_idelay_rst", int'(idelay_rst), 1);
    check("rst_calib_rst_n", int'(calib_rst_n), 0);
    check("rst_seq_busy", int'(seq_busy), 1);
    check("rst_retry_cnt", int'(retry_cnt), 0);
    rst200_n = 1'b1;
    n = 0;
    while (idelay_rst && n < 100) begin @(negedge clk200); n++; end
    check("powerup_pulse_width", n, 12);

    $display("scenario: ready rises 20 cycles after release");
    repeat (8) @(negedge clk200);
    idelay_ctrl_rdy = 1'b1;
    n = 0;
    do begin @(posedge clk200); #1; n++; end while (!calib_rst_n && n < 200);
    check("powerup_release_edges", n, 19);
    check("powerup_busy_at_release", int'(seq_busy), 0);
    check("powerup_retry_cnt", int'(retry_cnt), 0);
    @(negedge clk200);

    $display("scenario: one-cycle ready glitch at stable count 10");
    idelay_ctrl_rdy = 1'b0;
    restart = 1'b1;
    @(negedge clk200);
    restart = 1'b0;
    repeat (20) @(negedge clk200);
    idelay_ctrl_rdy = 1'b1;
    repeat (11) @(negedge clk200);
    idelay_ctrl_rdy = 1'b0;
    @(negedge clk200);
    idelay_ctrl_rdy = 1'b1;
    n = 0;
    do begin @(posedge clk200); #1; n++; end while (!calib_rst_n && n < 200);
    check("glitch_release_edges", n, 19);
    check("glitch_retry_cnt", int'(retry_cnt), 0);
    @(negedge clk200);

    $display("scenario: ready never rises, retries then error");
    idelay_ctrl_rdy = 1'b0;
    restart = 1'b1;
    @(negedge clk200);
    restart = 1'b0;
    starts.push_back(0);
    rets.push_back(int'(retry_cnt));
    prev = idelay_rst;
    err_at = -1;
    for (int i = 1; i <= 6400; i++) begin
      @(negedge clk200);
      if (idelay_rst && !prev) begin starts.push_back(i); rets.push_back(int'(retry_cnt)); end
      prev = idelay_rst;
      if (seq_error) begin err_at = i; break; end
    end
    check("timeout_pulse_count", starts.size(), 3);
    if (starts.size() == 3) begin
      check("timeout_pulse2_start", starts[1], 2060);
      check("timeout_pulse3_start", starts[2], 4120);
      check("timeout_retry_at_p1", rets[0], 0);
      check("timeout_retry_at_p2", rets[1], 1);
      check("timeout_retry_at_p3", rets[2], 2);
    end
    check("timeout_error_cycle", err_at, 6180);
    repeat (50) @(negedge clk200);
    check("error_sticky", int'(seq_error), 1);
    check("error_calib_rst_n", int'(calib_rst_n), 0);
    check("error_seq_busy", int'(seq_busy), 0);
    check("error_idelay_rst", int'(idelay_rst), 0);

    $display("scenario: restart out of error with ready high");
    idelay_ctrl_rdy = 1'b1;
    restart = 1'b1;
    @(negedge clk200);
    restart = 1'b0;
    check("restart_error_cleared", int'(seq_error), 0);
    check("restart_new_pulse", int'(idelay_rst), 1);
    n = 0;
    while (!calib_rst_n && n < 200) begin @(negedge clk200); n++; end
    check("restart_reaches_ready", int'(calib_rst_n), 1);
    check("restart_retry_cnt", int'(retry_cnt), 0);

    $display("scenario: ready lost for 5 cycles in READY");
    base = lost_total;
    idelay_ctrl_rdy = 1'b0;
    n = 0;
    do begin @(posedge clk200); #1; n++; end while (calib_rst_n && n < 50);
    check("loss_calib_low_edges", n, 3);
    check("loss_rdy_lost_high", int'(rdy_lost), 1);
    @(negedge clk200);
    repeat (2) @(negedge clk200);
    idelay_ctrl_rdy = 1'b1;
    n = 0;
    while (!calib_rst_n && n < 200) begin @(negedge clk200); n++; end
    check("loss_rerelease", int'(calib_rst_n), 1);
    check("loss_rdy_lost_pulses", lost_total - base, 1);

    $display("scenario: restart coincides with timeout");
    idelay_ctrl_rdy = 1'b0;
    restart = 1'b1;
    @(negedge clk200);
    restart = 1'b0;
    repeat (2059) @(negedge clk200);
    restart = 1'b1;
    @(negedge clk200);
    restart = 1'b0;
    check("prio_retry_cnt", int'(retry_cnt), 0);
    check("prio_idelay_rst", int'(idelay_rst), 1);

    $display("scenario: async reset mid stable check");
    idelay_ctrl_rdy = 1'b1;
    repeat (20) @(negedge clk200);
    #2;
    rst200_n = 1'b0;
    #1;
    check("async_idelay_rst", int'(idelay_rst), 1);
    check("async_calib_rst_n", int'(calib_rst_n), 0);
    check("async_seq_busy", int'(seq_busy), 1);
    check("async_retry_cnt", int'(retry_cnt), 0);
    @(negedge clk200);
    @(negedge clk200);
    rst200_n = 1'b1;

    $display("scenario: randomized ready and restart traffic");
    run_left = 0;
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk200);
      if (run_left == 0) begin
        idelay_ctrl_rdy = ~idelay_ctrl_rdy;
        if (idelay_ctrl_rdy)
          run_left = ((i / 3000) % 2 == 0) ? int'($urandom_range(10, 80)) : int'($urandom_range(1, 14));
        else
          run_left = int'($urandom_range(1, 25));
      end
      run_left--;
      restart = ($urandom_range(0, 1499) == 0);
    end
    restart = 1'b0;
    repeat (4) @(negedge clk200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
